// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core slice: instruction-memory geometry,
// loader FSM states and the opcode constants used by the instruction stream.
package mips_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM,
`endif
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream into the loader plus the instruction-memory write port it drives.
// The loader side uses the slave modport; the host/memory side uses master.
interface imem_loader_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes MSB-first into a 32-bit word and pulses word_valid
// for one cycle after the fourth byte is shifted in.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] shreg_q;

    assign last_byte = shift_en && (idx_q == 2'd3);

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= 2'd0;
            shreg_q    <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else if (clr) begin
            idx_q      <= 2'd0;
            shreg_q    <= 24'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= last_byte;
            if (shift_en) begin
                idx_q   <= idx_q + 2'd1;
                shreg_q <= {shreg_q[15:0], byte_in};
                if (last_byte) begin
                    word <= {shreg_q, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: 16-bit word count, then big-endian words.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [ADDR_W:0] words_loaded
);

    loader_state_t state_q, state_d;

    logic              in_ready;
    logic              accept;
    logic              data_accept;
    logic              start_ok;
    logic              last_byte;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       count_q;
    logic [15:0]       count_full;
    logic              count_zero;
    logic              count_over;
    logic              last_word;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W:0]   words_q;
    logic              err_q;
    logic              cpu_rst_q;

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] cksum_q;
    assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CKSUM);
`else
    assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA);
`endif

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign accept      = in_ready && bus.in_valid;
    assign data_accept = accept && (state_q == DATA);

    assign count_full = {count_q[15:8], bus.in_data};
    assign count_zero = (count_full == 16'd0);
    assign count_over = (count_full > 16'(DEPTH));
    assign last_word  = ((16'(words_q) + 16'd1) == count_q);
    assign word_idx   = (words_q >= (ADDR_W+1)'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                        : words_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: if (bus.in_valid) state_d = LEN_LO;
            LEN_LO: begin
                if (bus.in_valid) begin
                    if (count_over) begin
                        state_d = DONE;
                    end else if (count_zero) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = CKSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_byte && last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            CKSUM: if (bus.in_valid) state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
    end

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .shift_en   (data_accept),
        .byte_in    (bus.in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 16'd0;
            waddr_q   <= '0;
            words_q   <= '0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            if (start_ok) begin
                words_q <= '0;
                err_q   <= 1'b0;
            end
            if (accept && (state_q == LEN_HI)) count_q[15:8] <= bus.in_data;
            if (accept && (state_q == LEN_LO)) begin
                count_q[7:0] <= bus.in_data;
                if (count_over) err_q <= 1'b1;
            end
            // Address and count advance on the 4th-byte edge so they line up
            // with the registered write strobe one cycle later.
            if (last_byte) begin
                waddr_q <= word_idx;
                words_q <= words_q + {{ADDR_W{1'b0}}, 1'b1};
            end
`ifdef IMEM_LOADER_CKSUM_EN
            if (accept && (state_q == CKSUM) && (bus.in_data != cksum_q)) err_q <= 1'b1;
`endif
            // Core leaves reset only once DONE has been reached cleanly.
            cpu_rst_q <= start_ok || !((state_q == DONE) && !err_q);
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) cksum_q <= 8'd0;
        else if (data_accept) cksum_q <= cksum_q ^ bus.in_data;
    end
`endif

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = word_valid;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = word;
    assign cpu_rst        = cpu_rst_q;
    assign err            = err_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a stream-level reference model predicts the
// write sequence and status flags for each load.
module tb_imem_loader;
    import mips_pkg::*;

    typedef logic [31:0] word_q_t[$];
    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [31:0]            data;
    } wr_t;

    logic clk = 1'b0;
    logic rst, start;
    logic cpu_rst, busy, done, err;
    logic [IMEM_ADDR_W:0] words_loaded;

    int vectors     = 0;
    int miscompares = 0;
    wr_t obs_q[$];

    imem_loader_if #(.ADDR_W(IMEM_ADDR_W)) bus ();

    imem_loader #(.DEPTH(IMEM_DEPTH), .ADDR_W(IMEM_ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus.slave),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) obs_q.push_back(wr_t'{addr: bus.imem_waddr, data: bus.imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_we"},       bus.imem_we, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_err"},      err, 0);
        check({tag, "_waddr"},    bus.imem_waddr, 0);
        check({tag, "_wdata"},    bus.imem_wdata, 0);
        check({tag, "_words"},    words_loaded, 0);
        check({tag, "_cpu_rst"},  cpu_rst, 1);
    endtask

    // stall_pct < 0 inserts exactly one idle cycle before every byte.
    task automatic send_byte(input logic [7:0] b, input int stall_pct);
        int   waited = 0;
        logic rdy;
        if (stall_pct < 0) begin
            bus.in_valid = 1'b0;
            tick();
        end else begin
            while ($urandom_range(99) < stall_pct) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            rdy = bus.in_ready;
            tick();
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                check("byte_accept_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic word_q_t gen_words(input int n);
        word_q_t    q;
        logic [5:0] ops [6] = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) q.push_back($urandom);
            else q.push_back({ops[$urandom_range(5)], 26'($urandom)});
        end
        return q;
    endfunction

    task automatic run_load(input int count, input word_q_t w, input int stall_pct,
                            input int glitch_at, input bit bad_ck);
        logic [15:0] cnt16 = 16'(count);
        logic [7:0]  stream[$];
        wr_t         exp_q[$];
        logic [7:0]  ck = 8'h00;
        logic [31:0] cur;
        bit          over = (count > IMEM_DEPTH);
        bit          exp_err;
        int          n;

        stream.push_back(cnt16[15:8]);
        stream.push_back(cnt16[7:0]);
        if (!over) begin
            for (int i = 0; i < count; i++) begin
                cur = w[i];
                for (int k = 0; k < 4; k++) begin
                    stream.push_back(cur[31-8*k -: 8]);
                    ck = ck ^ cur[31-8*k -: 8];
                end
                exp_q.push_back(wr_t'{addr: IMEM_ADDR_W'(i), data: cur});
            end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        if (!over) stream.push_back(bad_ck ? (ck ^ 8'h01) : ck);
        exp_err = over || bad_ck;
`else
        exp_err = over;
`endif

        obs_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_ready", bus.in_ready, 1);
        check("start_busy",     busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr",  err, 0);
        check("start_words_clr", words_loaded, 0);
        check("start_cpu_rst",  cpu_rst, 1);

        foreach (stream[i]) begin
            if (i == glitch_at) start = 1'b1;
            send_byte(stream[i], stall_pct);
            start = 1'b0;
        end

        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_cpu_rst_held", cpu_rst, 1);
`ifndef IMEM_LOADER_CKSUM_EN
        if (!over && count > 0) check("end_last_we_with_done", bus.imem_we, 1);
`endif
        tick();
        check("cpu_rst_after_done", cpu_rst, exp_err);
        tick();
        check("err",          err, exp_err);
        check("done_sticky",  done, 1);
        check("in_ready_idle", bus.in_ready, 0);
        check("words_loaded", words_loaded, over ? 0 : count);
        check("write_count",  obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("waddr", obs_q[i].addr, exp_q[i].addr);
            check("wdata", obs_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        word_q_t     w;
        logic [15:0] cnt16;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();
        check_reset_state("idle");

        // start coincident with rst: rst wins
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_reset_state("rst_start");

        w.delete();
        w.push_back(32'h20080005);
        w.push_back(32'h00000000);
        run_load(2, w, 0, -1, 1'b0);
        run_load(2, w, -1, -1, 1'b0);
        run_load(1025, w, 0, -1, 1'b0);
        run_load(0, w, 0, -1, 1'b0);

        // rst during the 4th byte of word 1 of a 3-word load
        w = gen_words(3);
        obs_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt16 = 16'd3;
        send_byte(cnt16[15:8], 0);
        send_byte(cnt16[7:0], 0);
        for (int k = 0; k < 4; k++) send_byte(w[0][31-8*k -: 8], 0);
        for (int k = 0; k < 3; k++) send_byte(w[1][31-8*k -: 8], 0);
        bus.in_valid = 1'b1;
        bus.in_data  = w[1][7:0];
        rst          = 1'b1;
        tick();
        check("rst_edge_no_we", bus.imem_we, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("rst_after_no_we", bus.imem_we, 0);
        check_reset_state("mid_rst");
        check("mid_rst_writes", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            check("mid_rst_addr0", obs_q[0].addr, 0);
            check("mid_rst_data0", obs_q[0].data, w[0]);
        end
        run_load(3, gen_words(3), 0, -1, 1'b0);

        // start pulsed while busy must be ignored
        run_load(5, gen_words(5), 20, 9, 1'b0);

`ifdef IMEM_LOADER_CKSUM_EN
        w.delete();
        w.push_back(32'h20080005);
        run_load(1, w, 0, -1, 1'b0);
        run_load(1, w, 0, -1, 1'b1);
        run_load(4, gen_words(4), 30, -1, 1'b1);
`endif

        for (int t = 0; t < 8; t++) begin
            int c;
            c = $urandom_range(12, 1);
            run_load(c, gen_words(c), $urandom_range(60), -1, 1'b0);
        end

        run_load(IMEM_DEPTH, gen_words(IMEM_DEPTH), 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
